// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and a small op classification helper.
package mdu_pkg;

   localparam logic [2:0] MDU_NONE  = 3'd0;
   localparam logic [2:0] MDU_MULT  = 3'd1;
   localparam logic [2:0] MDU_MULTU = 3'd2;
   localparam logic [2:0] MDU_DIV   = 3'd3;
   localparam logic [2:0] MDU_DIVU  = 3'd4;
   localparam logic [2:0] MDU_MTHI  = 3'd5;
   localparam logic [2:0] MDU_MTLO  = 3'd6;

   localparam int MDU_MULT_CYCLES = 5;
   localparam int MDU_DIV_CYCLES  = 10;

   // Multiply and divide go through the staging registers and raise busy.
   function automatic logic isLongOp(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

   function automatic logic isDivOp(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the {hi, lo} staging value,
// including the divide-by-zero hold and signed overflow cases.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] result
);

   logic [63:0]        sProd;
   logic [63:0]        uProd;
   logic               divByZero;
   logic               divOverflow;
   logic signed [31:0] sDividend;
   logic signed [31:0] sDivisor;
   logic signed [31:0] sQuot;
   logic signed [31:0] sRem;
   logic [31:0]        uDivisor;
   logic [31:0]        uQuot;
   logic [31:0]        uRem;

   assign sProd = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign uProd = {32'd0, A} * {32'd0, B};

   assign divByZero   = (B == 32'd0);
   assign divOverflow = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

   // Substitute a divisor of 1 for the special cases so the dividers never
   // see zero or the unrepresentable quotient; those results are muxed out.
   assign sDividend = $signed(A);
   assign sDivisor  = (divByZero || divOverflow) ? 32'sd1 : $signed(B);
   assign uDivisor  = divByZero ? 32'd1 : B;

   assign sQuot = sDividend / sDivisor;
   assign sRem  = sDividend % sDivisor;
   assign uQuot = A / uDivisor;
   assign uRem  = A % uDivisor;

   always_comb begin
      result = {hi, lo};
      case (op)
         MDU_MULT:  result = sProd;
         MDU_MULTU: result = uProd;
         MDU_DIV: begin
            if (divByZero)
               result = {hi, lo};
            else if (divOverflow)
               result = {32'd0, 32'h8000_0000};
            else
               result = {sRem, sQuot};
         end
         MDU_DIVU: begin
            if (divByZero)
               result = {hi, lo};
            else
               result = {uRem, uQuot};
         end
         default:   result = {hi, lo};
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit holding HI/LO; long ops stage their result and
// commit it after a fixed latency while busy stalls the pipeline.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0] counter;
   logic [31:0]      hiStage;
   logic [31:0]      loStage;
   logic [63:0]      arithResult;
   logic             accept;

   mdu_arith uArith (
      .op     (op),
      .A      (A),
      .B      (B),
      .hi     (hi),
      .lo     (lo),
      .result (arithResult)
   );

   assign accept = start && !busy && (op != MDU_NONE);

   // Accepts only happen while idle, so they never overlap the countdown.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy    <= 1'b0;
         counter <= '0;
         hiStage <= '0;
         loStage <= '0;
         hi      <= '0;
         lo      <= '0;
      end else if (accept) begin
         if (isLongOp(op)) begin
            {hiStage, loStage} <= arithResult;
            counter            <= isDivOp(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy               <= 1'b1;
         end else if (op == MDU_MTHI) begin
            hi <= A;
         end else if (op == MDU_MTLO) begin
            lo <= A;
         end
      end else if (counter != '0) begin
         counter <= counter - 1'b1;
         if (counter == CNT_W'(1)) begin
            hi   <= hiStage;
            lo   <= loStage;
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: latency, arithmetic results,
// divide corner cases, busy lockout and reset abort.
module tb_mdu_unit;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checkCount;
   int passCount;
   int failCount;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one request across a single rising edge, then settle 1 time unit past it.
   task automatic applyStimulus(input logic s, input logic [2:0] o,
                                input logic [31:0] a, input logic [31:0] b);
      start = s;
      op    = o;
      A     = a;
      B     = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = MDU_NONE;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic doReset(input int cycles);
      reset = 1'b1;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   // Counts edges until busy drops, bounded so a stuck busy still reaches the summary.
   task automatic waitIdle(output int edges);
      edges = 0;
      while (busy === 1'b1 && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   int n;

   initial begin
      checkCount = 0;
      passCount  = 0;
      failCount  = 0;
      reset = 1'b0;
      start = 1'b0;
      op    = MDU_NONE;
      A     = '0;
      B     = '0;
      #2;

      doReset(2);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);

      // MULT aborted by reset after two cycles
      applyStimulus(1'b1, MDU_MULT, 32'd3, 32'd4);
      checkOutput("abort_busy_on", {31'd0, busy}, 32'd1);
      applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
      doReset(1);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_hi", hi, 32'd0);
      checkOutput("abort_lo", lo, 32'd0);
      repeat (8) applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
      checkOutput("abort_lo_later", lo, 32'd0);
      checkOutput("abort_hi_later", hi, 32'd0);

      // Signed multiply -2 * 3
      applyStimulus(1'b1, MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
      checkOutput("mult_busy", {31'd0, busy}, 32'd1);
      checkOutput("mult_lo_held", lo, 32'd0);
      waitIdle(n);
      checkOutput("mult_latency", n, 32'd5);
      checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
      checkOutput("mult_lo", lo, 32'hFFFF_FFFA);

      applyStimulus(1'b1, MDU_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
      checkOutput("multu_hi_held", hi, 32'hFFFF_FFFF);
      waitIdle(n);
      checkOutput("multu_latency", n, 32'd5);
      checkOutput("multu_hi", hi, 32'h0000_0002);
      checkOutput("multu_lo", lo, 32'hFFFF_FFFA);

      // Signed divide -7 / 2
      applyStimulus(1'b1, MDU_DIV, 32'hFFFF_FFF9, 32'd2);
      waitIdle(n);
      checkOutput("div_latency", n, 32'd10);
      checkOutput("div_lo", lo, 32'hFFFF_FFFD);
      checkOutput("div_hi", hi, 32'hFFFF_FFFF);

      applyStimulus(1'b1, MDU_DIVU, 32'd7, 32'd2);
      waitIdle(n);
      checkOutput("divu_lo", lo, 32'd3);
      checkOutput("divu_hi", hi, 32'd1);

      // Divide by zero leaves HI/LO as written by MTHI/MTLO
      applyStimulus(1'b1, MDU_MTHI, 32'h11, 32'd0);
      checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
      checkOutput("mthi_hi", hi, 32'h11);
      applyStimulus(1'b1, MDU_MTLO, 32'h22, 32'd0);
      checkOutput("mtlo_lo", lo, 32'h22);
      checkOutput("mtlo_hi_kept", hi, 32'h11);
      applyStimulus(1'b1, MDU_DIVU, 32'd5, 32'd0);
      checkOutput("div0_busy", {31'd0, busy}, 32'd1);
      waitIdle(n);
      checkOutput("div0_latency", n, 32'd10);
      checkOutput("div0_hi", hi, 32'h11);
      checkOutput("div0_lo", lo, 32'h22);

      // Signed overflow
      applyStimulus(1'b1, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      waitIdle(n);
      checkOutput("divovf_lo", lo, 32'h8000_0000);
      checkOutput("divovf_hi", hi, 32'h0);

      // Busy lockout: MULT 2*3 accepted at edge t0
      applyStimulus(1'b1, MDU_MULT, 32'd2, 32'd3);
      applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
      applyStimulus(1'b1, MDU_MTLO, 32'h0000_DEAD, 32'd0);
      checkOutput("lock_mtlo_ignored", lo, 32'h8000_0000);
      checkOutput("lock_still_busy", {31'd0, busy}, 32'd1);
      applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
      applyStimulus(1'b0, MDU_NONE, 32'd0, 32'd0);
      applyStimulus(1'b1, MDU_DIV, 32'd100, 32'd7);
      checkOutput("lock_fall_busy", {31'd0, busy}, 32'd0);
      checkOutput("lock_lo", lo, 32'd6);
      checkOutput("lock_hi", hi, 32'd0);
      applyStimulus(1'b1, MDU_DIV, 32'd100, 32'd7);
      checkOutput("lock_retry_busy", {31'd0, busy}, 32'd1);
      waitIdle(n);
      checkOutput("lock_retry_latency", n, 32'd10);
      checkOutput("lock_retry_lo", lo, 32'd14);
      checkOutput("lock_retry_hi", hi, 32'd2);

      // Single-cycle MTHI
      applyStimulus(1'b1, MDU_MTHI, 32'hCAFE_BABE, 32'd0);
      checkOutput("mthi2_hi", hi, 32'hCAFE_BABE);
      checkOutput("mthi2_busy", {31'd0, busy}, 32'd0);
      checkOutput("mthi2_lo", lo, 32'd14);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
